rtc_alarm_sched: RTL and testbench

- Multi-slot alarm scheduler for the RTC counter domain.
- Holds NUM_SLOT alarm entries, each with a compare value and an optional reload period.
- On every counter tick, time-multiplexes one wrap-safe comparator across all slots, then raises per-slot pending and overrun flags and a combined interrupt.
- Sits beside the RTC counter in the rtc clock domain. It is driven by the counter value and the prescaler tick; its config/clear port is fed by the bus-side register block through the existing CDC.

---
 rtl/rtc_alarm_sched.sv | 119 +++++++++++
 tb/tb_rtc_alarm_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_alarm_sched.sv
// rtc_alarm_sched: multi-slot alarm scheduler that scans all slots with one shared comparator on each counter tick
// Ports: clk_i/rst_i clock and sync reset; cnt_i/tick_i counter value and advance pulse;
//        cfg_* slot configuration handshake; clr_i W1C mask for pend/ovr;
//        en_o/pend_o/ovr_o per-slot state; busy_o scan active; miss_o sticky tick-while-busy; irq_o combined interrupt.
module rtc_alarm_sched #(
    parameter int NUM_SLOT = 4,
    parameter int CNT_WIDTH = 32,
    localparam int IDX_WIDTH = $clog2(NUM_SLOT)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [CNT_WIDTH-1:0] cnt_i,
    input  logic                 tick_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [IDX_WIDTH-1:0] cfg_idx_i,
    input  logic                 cfg_en_i,
    input  logic                 cfg_ie_i,
    input  logic [CNT_WIDTH-1:0] cfg_cmp_i,
    input  logic [CNT_WIDTH-1:0] cfg_per_i,
    input  logic [NUM_SLOT-1:0]  clr_i,
    output logic [NUM_SLOT-1:0]  en_o,
    output logic [NUM_SLOT-1:0]  pend_o,
    output logic [NUM_SLOT-1:0]  ovr_o,
    output logic                 busy_o,
    output logic                 miss_o,
    output logic                 irq_o
);
    typedef enum logic {IDLE, SCAN} state_t;
    state_t                r_state, w_next;
    logic [IDX_WIDTH-1:0]  r_idx;
    logic [CNT_WIDTH-1:0]  r_snap;
    logic                  r_rtick, r_miss;
    logic [NUM_SLOT-1:0]   r_en, r_ie, r_pend, r_ovr;
    logic [CNT_WIDTH-1:0]  r_cmp [NUM_SLOT];
    logic [CNT_WIDTH-1:0]  r_per [NUM_SLOT];
    logic                  w_last, w_start, w_behind, w_hit, w_fire, w_cfg_ok;
    logic [NUM_SLOT-1:0]   w_set, w_clr;

    assign w_last   = 32'(r_idx) == NUM_SLOT - 1;
    assign w_start  = r_state == IDLE && (tick_i || r_rtick);
    // sign bit of snap-cmp: set means the counter is still before the compare point (wrap-safe within half range)
    assign w_behind = 1'((r_snap - r_cmp[r_idx]) >> (CNT_WIDTH - 1));
    assign w_hit    = r_state == SCAN && r_en[r_idx] && !w_behind;
    assign w_fire   = cfg_valid_i && cfg_ready_o;
    assign w_cfg_ok = w_fire && 32'(cfg_idx_i) < NUM_SLOT;

    always_comb begin
        w_set = '0;
        w_clr = clr_i;
        for (int s = 0; s < NUM_SLOT; s++) begin
            w_set[s] = w_hit && 32'(r_idx) == s;
            if (w_cfg_ok && 32'(cfg_idx_i) == s) w_clr[s] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE) w_next = w_start ? SCAN : IDLE;
        else w_next = w_last ? IDLE : SCAN;
    end

    always_comb begin
        cfg_ready_o = r_state == IDLE;
        busy_o      = r_state == SCAN;
        irq_o       = |(r_pend & r_ie);
        en_o        = r_en;
        pend_o      = r_pend;
        ovr_o       = r_ovr;
        miss_o      = r_miss;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_idx   <= '0;
            r_snap  <= '0;
            r_rtick <= 1'b0;
            r_miss  <= 1'b0;
            r_en    <= '0;
            r_ie    <= '0;
            r_pend  <= '0;
            r_ovr   <= '0;
            for (int s = 0; s < NUM_SLOT; s++) begin
                r_cmp[s] <= '0;
                r_per[s] <= '0;
            end
        end else begin
            // a match sets pend and beats a same-cycle clear; overrun only counts if the old pend survived
            r_pend <= w_set | (r_pend & ~w_clr);
            r_ovr  <= (w_set & r_pend & ~w_clr) | (r_ovr & ~(w_clr & ~w_set));
            if (w_hit) begin
                if (r_per[r_idx] != '0) r_cmp[r_idx] <= r_cmp[r_idx] + r_per[r_idx];
                else r_en[r_idx] <= 1'b0;
            end
            if (w_cfg_ok) begin
                r_en[cfg_idx_i]  <= cfg_en_i;
                r_ie[cfg_idx_i]  <= cfg_ie_i;
                r_cmp[cfg_idx_i] <= cfg_cmp_i;
                r_per[cfg_idx_i] <= cfg_per_i;
            end
            if (w_start) begin
                r_snap  <= cnt_i;
                r_idx   <= '0;
                r_rtick <= 1'b0;
            end else if (r_state == SCAN) begin
                r_idx <= w_last ? '0 : r_idx + 1'b1;
                if (tick_i) begin
                    r_rtick <= 1'b1;
                    r_miss  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rtc_alarm_sched.sv
// tb_rtc_alarm_sched: directed bench with a per-cycle behavioural model and literal checkpoints
module tb_rtc_alarm_sched;
    localparam int N = 4;
    localparam int W = 32;
    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [W-1:0]  cnt_i = '0;
    logic          tick_i = 1'b0;
    logic          cfg_valid_i = 1'b0;
    logic          cfg_ready_o;
    logic [1:0]    cfg_idx_i = '0;
    logic          cfg_en_i = 1'b0;
    logic          cfg_ie_i = 1'b0;
    logic [W-1:0]  cfg_cmp_i = '0;
    logic [W-1:0]  cfg_per_i = '0;
    logic [N-1:0]  clr_i = '0;
    logic [N-1:0]  en_o, pend_o, ovr_o;
    logic          busy_o, miss_o, irq_o;
    int checks = 0;
    int fails = 0;

    rtc_alarm_sched #(.NUM_SLOT(N), .CNT_WIDTH(W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cnt_i(cnt_i), .tick_i(tick_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_idx_i(cfg_idx_i),
        .cfg_en_i(cfg_en_i), .cfg_ie_i(cfg_ie_i), .cfg_cmp_i(cfg_cmp_i), .cfg_per_i(cfg_per_i),
        .clr_i(clr_i), .en_o(en_o), .pend_o(pend_o), .ovr_o(ovr_o),
        .busy_o(busy_o), .miss_o(miss_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // model: slot table plus "which slot is the scan on" (-1 when no scan is running)
    bit           m_ok = 0;
    logic [W-1:0] m_cmp [N];
    logic [W-1:0] m_per [N];
    logic [W-1:0] m_snap;
    bit [N-1:0]   m_en, m_ie, m_pend, m_ovr;
    int           m_pos;
    bit           m_rtick, m_miss;

    always @(posedge clk_i) begin
        bit fire, hit;
        int s;
        bit [N-1:0] clr;
        if (rst_i) begin
            m_ok = 1; m_en = 0; m_ie = 0; m_pend = 0; m_ovr = 0;
            m_pos = -1; m_rtick = 0; m_miss = 0; m_snap = 0;
            for (int i = 0; i < N; i++) begin m_cmp[i] = 0; m_per[i] = 0; end
        end else if (m_ok) begin
            fire = cfg_valid_i && m_pos < 0;
            clr = clr_i;
            if (fire) clr[cfg_idx_i] = 1;
            s = m_pos;
            hit = 0;
            if (s >= 0) hit = m_en[s] && ((m_snap - m_cmp[s]) < 32'h8000_0000);
            for (int i = 0; i < N; i++) begin
                if (hit && i == s) begin
                    if (m_pend[i] && !clr[i]) m_ovr[i] = 1;
                    m_pend[i] = 1;
                end else if (clr[i]) begin
                    m_pend[i] = 0;
                    m_ovr[i] = 0;
                end
            end
            if (hit) begin
                if (m_per[s] != 0) m_cmp[s] = m_cmp[s] + m_per[s];
                else m_en[s] = 0;
            end
            if (fire) begin
                m_en[cfg_idx_i] = cfg_en_i; m_ie[cfg_idx_i] = cfg_ie_i;
                m_cmp[cfg_idx_i] = cfg_cmp_i; m_per[cfg_idx_i] = cfg_per_i;
            end
            if (m_pos < 0) begin
                if (tick_i || m_rtick) begin m_snap = cnt_i; m_pos = 0; m_rtick = 0; end
            end else begin
                if (tick_i) begin m_rtick = 1; m_miss = 1; end
                m_pos = (m_pos == N - 1) ? -1 : m_pos + 1;
            end
        end
    end

    always @(negedge clk_i) begin
        if (m_ok) begin
            chk("m_en", en_o, m_en);
            chk("m_pend", pend_o, m_pend);
            chk("m_ovr", ovr_o, m_ovr);
            chk("m_busy", busy_o, m_pos >= 0);
            chk("m_ready", cfg_ready_o, m_pos < 0);
            chk("m_miss", miss_o, m_miss);
            chk("m_irq", irq_o, |(m_pend & m_ie));
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic tick(input logic [W-1:0] v);
        cnt_i = v;
        tick_i = 1;
        step();
        tick_i = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 40) begin step(); n++; end
        chk("scan_end", busy_o, 0);
    endtask

    task automatic cfg(input int idx, input bit en, input bit ie, input logic [W-1:0] cmp, input logic [W-1:0] per);
        int n = 0;
        bit r = 0;
        cfg_idx_i = 2'(idx); cfg_en_i = en; cfg_ie_i = ie; cfg_cmp_i = cmp; cfg_per_i = per;
        cfg_valid_i = 1;
        while (!r && n < 40) begin r = cfg_ready_o; step(); n++; end
        cfg_valid_i = 0;
        chk("cfg_accept", r, 1);
    endtask

    task automatic clear(input logic [N-1:0] m);
        clr_i = m;
        step();
        clr_i = 0;
    endtask

    initial begin
        logic [12:0] bz, rd;
        bit acc;
        int n;
        step(); step();
        rst_i = 0;
        step();
        chk("rst_pend", pend_o, 0); chk("rst_ovr", ovr_o, 0); chk("rst_en", en_o, 0);
        chk("rst_busy", busy_o, 0); chk("rst_miss", miss_o, 0); chk("rst_irq", irq_o, 0);
        chk("rst_ready", cfg_ready_o, 1);

        tick(0);
        n = 0;
        while (busy_o && n < 20) begin n++; step(); end
        chk("busy_len", n, 4);
        chk("empty_pend", pend_o, 0);

        cfg(0, 1, 1, 10, 0);
        tick(9); wait_idle();
        chk("s0_early", pend_o, 0);
        tick(10);
        chk("s0_lat0", pend_o[0], 0);
        step();
        chk("s0_lat1", pend_o[0], 1);
        chk("s0_irq", irq_o, 1);
        wait_idle();
        chk("s0_oneshot", en_o[0], 0);
        tick(11); wait_idle();
        chk("s0_noovr", ovr_o, 0);
        chk("s0_pend", pend_o, 4'b0001);
        clear(4'b0001);

        cfg(2, 1, 0, 100, 50);
        tick(100); wait_idle();
        chk("s2_pend", pend_o, 4'b0100);
        chk("s2_irq_off", irq_o, 0);
        tick(150); wait_idle();
        chk("s2_ovr", ovr_o, 4'b0100);
        clear(4'b0100);
        chk("s2_clr_pend", pend_o, 0); chk("s2_clr_ovr", ovr_o, 0);
        tick(199); wait_idle();
        chk("s2_199", pend_o, 0);
        tick(200); wait_idle();
        chk("s2_200", pend_o, 4'b0100);
        cfg(2, 0, 0, 0, 0);
        chk("s2_cfgclr", pend_o, 0);

        cfg(1, 1, 1, 32'hFFFF_FFF0, 32'h20);
        tick(32'hFFFF_FFF0); wait_idle();
        chk("wrap_hit", pend_o, 4'b0010);
        chk("wrap_irq", irq_o, 1);
        clear(4'b0010);
        tick(32'h5); wait_idle();
        chk("wrap_5", pend_o, 0);
        tick(32'h10); wait_idle();
        chk("wrap_10", pend_o, 4'b0010);
        clear(4'b0010);

        tick(32'h20);
        cfg_idx_i = 3; cfg_en_i = 1; cfg_ie_i = 1; cfg_cmp_i = 32'h20; cfg_per_i = 32'h100;
        cfg_valid_i = 1;
        for (int k = 0; k < 13; k++) begin
            bz[k] = busy_o;
            rd[k] = cfg_ready_o;
            tick_i = (k == 0 || k == 2);
            acc = cfg_valid_i && cfg_ready_o;
            step();
            if (acc) cfg_valid_i = 0;
        end
        chk("rescan_busy", bz, 13'b0000111101111);
        chk("rescan_ready", rd, 13'b1111000010000);
        chk("rescan_cfgdone", cfg_valid_i, 0);
        chk("rescan_miss", miss_o, 1);
        chk("rescan_en3", en_o, 4'b1010);
        chk("rescan_pend3", pend_o, 4'b1000);

        tick(32'h120);
        step(); step(); step();
        clr_i = 4'b1000;
        step();
        clr_i = 0;
        chk("clrwin_pend", pend_o[3], 1);
        chk("clrwin_ovr", ovr_o[3], 0);
        wait_idle();

        tick(32'h500);
        step();
        rst_i = 1;
        step();
        chk("mid_pend", pend_o, 0); chk("mid_ovr", ovr_o, 0); chk("mid_en", en_o, 0);
        chk("mid_miss", miss_o, 0); chk("mid_busy", busy_o, 0); chk("mid_ready", cfg_ready_o, 1);
        chk("mid_irq", irq_o, 0);
        rst_i = 0;
        step(); step(); step();
        chk("post_pend", pend_o, 0);
        chk("post_busy", busy_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
